// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with run/stop control, plus
// sync, data-enable and start strobes delayed PIPE_DELAY enables behind the counters.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int CW         = 10,
    parameter int PIPE_DELAY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    input  logic          run,
    output logic [CW-1:0] x_out,
    output logic [CW-1:0] y_out,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          active
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);

    if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_cw_check
        $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_pipe_check
        $error("vga_timing_gen: PIPE_DELAY must be 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_STOP_PEND = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;
    logic          w_line_last;
    logic          w_frame_last;
    logic [4:0]    w_stage0;
    logic [4:0]    r_pipe [PIPE_DELAY];
    logic [4:0]    w_out;

    assign w_line_last  = (r_x == X_LAST);
    assign w_frame_last = w_line_last && (r_y == Y_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            S_IDLE: begin
                w_x_nxt = '0;
                w_y_nxt = '0;
                if (run) w_state_nxt = S_RUN;
            end
            S_RUN, S_STOP_PEND: begin
                // A stop request only takes effect on the last pixel of the frame.
                if (r_state == S_STOP_PEND && w_frame_last && !run) begin
                    w_state_nxt = S_IDLE;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                end else begin
                    w_state_nxt = run ? S_RUN : S_STOP_PEND;
                    if (w_line_last) begin
                        w_x_nxt = '0;
                        w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + CW'(1);
                    end else begin
                        w_x_nxt = r_x + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_x_nxt     = '0;
                w_y_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else if (pix_en) begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    // Stage 0 is packed as {hs, vs, de, ls, fs}, all forced low while idle.
    always_comb begin
        w_stage0 = '0;
        if (r_state != S_IDLE) begin
            w_stage0[4] = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
            w_stage0[3] = (r_y >= VS_FIRST) && (r_y <= VS_LAST);
            w_stage0[2] = (r_x < X_ACT) && (r_y < Y_ACT);
            w_stage0[1] = (r_x == '0);
            w_stage0[0] = (r_x == '0) && (r_y == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= '0;
        end else if (pix_en) begin
            r_pipe[0] <= w_stage0;
            for (int i = 1; i < PIPE_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_out       = r_pipe[PIPE_DELAY-1];
    assign hsync       = w_out[4] ? H_POL : ~H_POL;
    assign vsync       = w_out[3] ? V_POL : ~V_POL;
    assign de          = w_out[2];
    assign line_start  = w_out[1];
    assign frame_start = w_out[0];
    assign x_out       = r_x;
    assign y_out       = r_y;
    assign active      = (r_state != S_IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 14x7 raster with active-high syncs and a
// three-enable output delay, against a frame-position reference model.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit HPOL = 1'b1, VPOL = 1'b1;
    localparam int CW = 4;
    localparam int PD = 3;

    logic clk = 1'b0;
    logic rst_n, pix_en, run;
    logic [CW-1:0] x_out, y_out;
    logic hsync, vsync, de, line_start, frame_start, active;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(HPOL), .V_POL(VPOL), .CW(CW), .PIPE_DELAY(PD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run),
        .x_out(x_out), .y_out(y_out), .hsync(hsync), .vsync(vsync),
        .de(de), .line_start(line_start), .frame_start(frame_start),
        .active(active)
    );

    int checks = 0;
    int errors = 0;

    // Reference: mode 0 idle, 1 running, 2 stop pending; queue holds delayed {hs,vs,de,ls,fs}.
    int mmode, mx, my;
    logic [4:0] mq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] stage0(input int mode, input int x, input int y);
        logic [4:0] s;
        s = '0;
        if (mode != 0) begin
            s[4] = (x >= HA + HF) && (x < HA + HF + HS);
            s[3] = (y >= VA + VF) && (y < VA + VF + VS);
            s[2] = (x < HA) && (y < VA);
            s[1] = (x == 0);
            s[0] = (x == 0) && (y == 0);
        end
        return s;
    endfunction

    task automatic model_reset();
        mmode = 0; mx = 0; my = 0;
        mq.delete();
        repeat (PD) mq.push_back(5'b0);
    endtask

    task automatic model_step(input logic pe, input logic rn);
        int pos;
        if (!pe) return;
        mq.push_front(stage0(mmode, mx, my));
        void'(mq.pop_back());
        if (mmode == 0) begin
            if (rn) mmode = 1;
        end else if (mmode == 2 && mx == HT - 1 && my == VT - 1 && !rn) begin
            mmode = 0; mx = 0; my = 0;
        end else begin
            pos = (my * HT + mx + 1) % (HT * VT);
            mx = pos % HT;
            my = pos / HT;
            mmode = rn ? 1 : 2;
        end
    endtask

    task automatic compare_all(input string nm);
        logic [4:0] o;
        logic [2*CW+5:0] exp, act;
        o   = mq[PD-1];
        exp = {CW'(mx), CW'(my), o[4] ? HPOL : ~HPOL, o[3] ? VPOL : ~VPOL,
               o[2], o[1], o[0], mmode != 0};
        act = {x_out, y_out, hsync, vsync, de, line_start, frame_start, active};
        check(nm, 32'(act), 32'(exp));
    endtask

    task automatic cycle(input logic pe, input logic rn);
        pix_en = pe;
        run    = rn;
        @(posedge clk);
        model_step(pe, rn);
        @(negedge clk);
        compare_all("model");
    endtask

    typedef struct {
        logic pe;
        logic rn;
        int   x;
        int   y;
        logic act;
        logic de;
        logic fs;
        logic hs;
    } vec_t;

    vec_t tab[7];

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, hs_n, vs_n, de_n;
        bit dropped;
        tab[0] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[1] = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[2] = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[3] = '{1'b1, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[4] = '{1'b1, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[5] = '{1'b1, 1'b1, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[6] = '{1'b0, 1'b1, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; pix_en = 1'b0; run = 1'b0;
        model_reset();
        #3;
        check("rst_hsync", 32'(hsync), 32'(0));
        check("rst_vsync", 32'(vsync), 32'(0));
        check("rst_de", 32'(de), 32'(0));
        check("rst_x", 32'(x_out), 32'(0));
        check("rst_y", 32'(y_out), 32'(0));
        check("rst_active", 32'(active), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cycle(tab[i].pe, tab[i].rn);
            check("tab_x", 32'(x_out), 32'(tab[i].x));
            check("tab_y", 32'(y_out), 32'(tab[i].y));
            check("tab_active", 32'(active), 32'(tab[i].act));
            check("tab_de", 32'(de), 32'(tab[i].de));
            check("tab_fs", 32'(frame_start), 32'(tab[i].fs));
            check("tab_hsync", 32'(hsync), 32'(tab[i].hs));
        end

        // Full frame: period and per-frame high counts of each delayed signal.
        n = 0;
        do begin cycle(1'b1, 1'b1); n++; end while (!frame_start && n < 200);
        check("fs_found", 32'(frame_start), 32'(1));
        k = 0; hs_n = 0; vs_n = 0; de_n = 0;
        do begin
            cycle(1'b1, 1'b1); k++;
            hs_n += int'(hsync); vs_n += int'(vsync); de_n += int'(de);
        end while (!frame_start && k < 300);
        check("frame_period", 32'(k), 32'(HT * VT));
        check("hsync_count", 32'(hs_n), 32'(HS * VT));
        check("vsync_count", 32'(vs_n), 32'(VS * HT));
        check("de_count", 32'(de_n), 32'(HA * VA));

        // Stop mid-frame: the frame completes, then the generator idles.
        n = 0;
        while (!(mx == 3 && my == 2) && n < 200) begin cycle(1'b1, 1'b1); n++; end
        n = 0;
        do begin cycle(1'b1, 1'b0); n++; end while (active && n < 200);
        check("stop_cycles", 32'(n), 32'((HT * VT - 1) - (2 * HT + 3) + 1));
        check("stop_x", 32'(x_out), 32'(0));
        check("stop_y", 32'(y_out), 32'(0));
        repeat (PD + 2) cycle(1'b1, 1'b0);
        check("idle_de", 32'(de), 32'(0));

        // Stop request withdrawn mid-frame: no gap in frame timing.
        n = 0;
        do begin cycle(1'b1, 1'b1); n++; end while (!frame_start && n < 200);
        check("restart_fs", 32'(n), 32'(PD + 1));
        k = 0; dropped = 1'b0;
        do begin
            cycle(1'b1, (k >= 20 && k < 40) ? 1'b0 : 1'b1); k++;
            if (!active) dropped = 1'b1;
        end while (!frame_start && k < 300);
        check("reraise_period", 32'(k), 32'(HT * VT));
        check("reraise_active", 32'(dropped), 32'(0));

        // Asynchronous reset mid-line while de is high.
        n = 0;
        while (!(mx == 6 && my == 1) && n < 200) begin cycle(1'b1, 1'b1); n++; end
        check("pre_reset_de", 32'(de), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_de", 32'(de), 32'(0));
        check("async_x", 32'(x_out), 32'(0));
        check("async_active", 32'(active), 32'(0));
        check("async_hsync", 32'(hsync), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin cycle(1'b1, 1'b1); n++; end while (!frame_start && n < 20);
        check("post_reset_fs", 32'(n), 32'(PD + 1));

        // Random enables and run requests against the reference model.
        begin
            logic rn_r;
            rn_r = 1'b1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 149) == 0) rn_r = ~rn_r;
                cycle($urandom_range(0, 3) != 0, rn_r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
